// File: rtl/bomb_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// bomb_pkg : shared defaults, slot-state enum and cell coordinate type | rev 1.0
// ----------------------------------------------------------------------------
package bomb_pkg;

  localparam int SLOTS_DEFAULT      = 8;
  localparam int FUSE_TICKS_DEFAULT = 4;

  typedef logic [7:0] coord_t;

  typedef enum logic [1:0] {
    SLOT_FREE    = 2'd0,
    SLOT_ARMED   = 2'd1,
    SLOT_PENDING = 2'd2
  } slot_state_t;

endpackage
`default_nettype wire

// File: rtl/bomb_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// bomb_if : player requests, occupancy query and detonation stream | rev 1.0
// ----------------------------------------------------------------------------
interface bomb_if;
  import bomb_pkg::*;

  logic       tick;
  logic       p1_set_bomb;
  logic       p2_set_bomb;
  coord_t     p1_coordinate;
  coord_t     p2_coordinate;
  logic [2:0] bomb_num_1;
  logic [2:0] bomb_num_2;
  logic       expl_valid;
  coord_t     expl_coord;
  logic       expl_owner;
  logic       expl_ready;
  coord_t     query_coord;
  logic       query_hit;
  logic       p1_drop;
  logic       p2_drop;

  modport master (
    output tick, p1_set_bomb, p2_set_bomb, p1_coordinate, p2_coordinate,
    output expl_ready, query_coord,
    input  bomb_num_1, bomb_num_2, expl_valid, expl_coord, expl_owner,
    input  query_hit, p1_drop, p2_drop
  );

  modport slave (
    input  tick, p1_set_bomb, p2_set_bomb, p1_coordinate, p2_coordinate,
    input  expl_ready, query_coord,
    output bomb_num_1, bomb_num_2, expl_valid, expl_coord, expl_owner,
    output query_hit, p1_drop, p2_drop
  );

endinterface
`default_nettype wire

// File: rtl/bomb_slot.sv
`default_nettype none
// ----------------------------------------------------------------------------
// bomb_slot : one bomb slot holding state, coordinate, owner and fuse | rev 1.0
// ----------------------------------------------------------------------------
module bomb_slot
  import bomb_pkg::*;
#(
  parameter int FUSE_TICKS = FUSE_TICKS_DEFAULT
) (
  input  wire logic  clk,
  input  wire logic  rst,
  input  wire logic  i_alloc,
  input  coord_t     i_alloc_coord,
  input  wire logic  i_alloc_owner,
  input  wire logic  i_tick,
  input  wire logic  i_release,
  output slot_state_t o_state,
  output coord_t     o_coord,
  output logic       o_owner,
  output logic       o_fire
);

  localparam int c_FW = $clog2(FUSE_TICKS + 1);

  slot_state_t     r_state;
  coord_t          r_coord;
  logic            r_owner;
  logic [c_FW-1:0] r_fuse;

  // Last tick of the fuse; lets the manager present the slot without an extra cycle.
  assign o_fire  = (r_state == SLOT_ARMED) && i_tick && (r_fuse == c_FW'(1));
  assign o_state = r_state;
  assign o_coord = r_coord;
  assign o_owner = r_owner;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= SLOT_FREE;
      r_coord <= '0;
      r_owner <= 1'b0;
      r_fuse  <= '0;
    end else begin
      case (r_state)
        SLOT_FREE: begin
          if (i_alloc) begin
            r_state <= SLOT_ARMED;
            r_coord <= i_alloc_coord;
            r_owner <= i_alloc_owner;
            r_fuse  <= c_FW'(FUSE_TICKS);
          end
        end
        SLOT_ARMED: begin
          if (i_tick) begin
            r_fuse <= r_fuse - c_FW'(1);
            if (o_fire) r_state <= SLOT_PENDING;
          end
        end
        SLOT_PENDING: begin
          if (i_release) r_state <= SLOT_FREE;
        end
        default: r_state <= SLOT_FREE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/bomb_manager.sv
`default_nettype none
// ----------------------------------------------------------------------------
// bomb_manager : shared bomb-slot pool with fuses and a detonation stream | rev 1.0
// ----------------------------------------------------------------------------
module bomb_manager
  import bomb_pkg::*;
#(
  parameter int SLOTS      = SLOTS_DEFAULT,
  parameter int FUSE_TICKS = FUSE_TICKS_DEFAULT
) (
  input wire logic clk,
  input wire logic rst,
  bomb_if.slave    bus
);

  localparam int c_IW = (SLOTS > 1) ? $clog2(SLOTS) : 1;

  slot_state_t      w_state [SLOTS];
  coord_t           w_coord [SLOTS];
  logic [SLOTS-1:0] w_owner, w_fire, w_a1, w_a2, w_rel;
  logic             w_p1_dup, w_p2_dup, w_p1_ok, w_p2_ok;
  logic             w_p1_found, w_p2_found, w_cand_found, w_qhit;
  logic [c_IW-1:0]  w_p1_idx, w_p2_idx, w_cand_idx;
  logic [2:0]       w_cnt1, w_cnt2;

  logic             r_valid, r_owner, r_drop1, r_drop2;
  logic [c_IW-1:0]  r_idx;
  coord_t           r_coord;

  always_comb begin
    w_p1_dup = 1'b0;
    w_p2_dup = 1'b0;
    w_qhit   = 1'b0;
    w_cnt1   = '0;
    w_cnt2   = '0;
    for (int i = 0; i < SLOTS; i++) begin
      if (w_state[i] != SLOT_FREE) begin
        if (w_coord[i] == bus.p1_coordinate) w_p1_dup = 1'b1;
        if (w_coord[i] == bus.p2_coordinate) w_p2_dup = 1'b1;
        if (w_coord[i] == bus.query_coord)   w_qhit   = 1'b1;
        if (w_owner[i]) w_cnt2 = w_cnt2 + 3'd1;
        else            w_cnt1 = w_cnt1 + 3'd1;
      end
    end
  end

  // P1 takes the lowest free slot, P2 the lowest one left over.
  always_comb begin
    w_p1_found = 1'b0;
    w_p1_idx   = '0;
    for (int i = SLOTS - 1; i >= 0; i--) begin
      if (w_state[i] == SLOT_FREE) begin
        w_p1_found = 1'b1;
        w_p1_idx   = c_IW'(i);
      end
    end
    w_p1_ok = bus.p1_set_bomb && !w_p1_dup && w_p1_found;
    w_a1 = '0;
    if (w_p1_ok) w_a1[w_p1_idx] = 1'b1;

    w_p2_found = 1'b0;
    w_p2_idx   = '0;
    for (int i = SLOTS - 1; i >= 0; i--) begin
      if ((w_state[i] == SLOT_FREE) && !w_a1[i]) begin
        w_p2_found = 1'b1;
        w_p2_idx   = c_IW'(i);
      end
    end
    w_p2_ok = bus.p2_set_bomb && !w_p2_dup && w_p2_found &&
              !(w_p1_ok && (bus.p1_coordinate == bus.p2_coordinate));
    w_a2 = '0;
    if (w_p2_ok) w_a2[w_p2_idx] = 1'b1;
  end

  always_comb begin
    w_cand_found = 1'b0;
    w_cand_idx   = '0;
    for (int i = SLOTS - 1; i >= 0; i--) begin
      if ((w_state[i] == SLOT_PENDING) || w_fire[i]) begin
        w_cand_found = 1'b1;
        w_cand_idx   = c_IW'(i);
      end
    end
    w_rel = '0;
    if (r_valid && bus.expl_ready) w_rel[r_idx] = 1'b1;
  end

  for (genvar i = 0; i < SLOTS; i++) begin : g_slot
    bomb_slot #(
      .FUSE_TICKS(FUSE_TICKS)
    ) u_slot (
      .clk          (clk),
      .rst          (rst),
      .i_alloc      (w_a1[i] | w_a2[i]),
      .i_alloc_coord(w_a1[i] ? bus.p1_coordinate : bus.p2_coordinate),
      .i_alloc_owner(w_a2[i]),
      .i_tick       (bus.tick),
      .i_release    (w_rel[i]),
      .o_state      (w_state[i]),
      .o_coord      (w_coord[i]),
      .o_owner      (w_owner[i]),
      .o_fire       (w_fire[i])
    );
  end

  // Output slot is latched once and held; a new slot is chosen only after the handshake cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_idx   <= '0;
      r_coord <= '0;
      r_owner <= 1'b0;
      r_drop1 <= 1'b0;
      r_drop2 <= 1'b0;
    end else begin
      r_drop1 <= bus.p1_set_bomb && !w_p1_ok;
      r_drop2 <= bus.p2_set_bomb && !w_p2_ok;
      if (r_valid) begin
        if (bus.expl_ready) r_valid <= 1'b0;
      end else if (w_cand_found) begin
        r_valid <= 1'b1;
        r_idx   <= w_cand_idx;
        r_coord <= w_coord[w_cand_idx];
        r_owner <= w_owner[w_cand_idx];
      end
    end
  end

  assign bus.expl_valid = r_valid;
  assign bus.expl_coord = r_coord;
  assign bus.expl_owner = r_owner;
  assign bus.p1_drop    = r_drop1;
  assign bus.p2_drop    = r_drop2;
  assign bus.bomb_num_1 = w_cnt1;
  assign bus.bomb_num_2 = w_cnt2;
  assign bus.query_hit  = w_qhit;

endmodule
`default_nettype wire

// File: doc/bomb_manager.md
BOMB_MANAGER -- requirements
Module: bomb_manager

Interface
REQ-001 SHALL have parameter SLOTS, default 8, total bomb slots shared by both players.
REQ-002 SHALL have parameter FUSE_TICKS, default 4, ticks from placement to detonation.
REQ-003 SHALL have port clk, input, 1, clock; reset rst, asynchronous, active-high; clock clk.
REQ-004 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-005 SHALL have port tick, input, 1, one-cycle fuse time-base pulse.
REQ-006 SHALL have ports p1_set_bomb / p2_set_bomb, input, 1, one-cycle placement request.
REQ-007 SHALL have ports p1_coordinate / p2_coordinate, input, 8, cell index 16*y+x, sampled with the set_bomb pulse.
REQ-008 SHALL have ports bomb_num_1 / bomb_num_2, output, 3, occupied slots owned by each player.
REQ-009 SHALL have ports expl_valid (output, 1), expl_coord (output, 8), expl_owner (output, 1, 0=P1, 1=P2), expl_ready (input, 1); valid/ready detonation stream.
REQ-010 SHALL have ports query_coord (input, 8) and query_hit (output, 1, combinational): an occupied slot holds query_coord.
REQ-011 SHALL have ports p1_drop / p2_drop, output, 1, one-cycle pulse when a request is rejected.

Function
REQ-012 SHALL give each slot a state FREE, ARMED or PENDING, with coord, owner and fuse counter.
REQ-013 SHALL allocate a set_bomb request to the lowest-index FREE slot, ARMED with fuse=FUSE_TICKS, visible on bomb_num and query_hit the next cycle.
REQ-014 SHALL reject and pulse *_drop the next cycle when no FREE slot exists or the coordinate is already occupied.
REQ-015 SHALL, on simultaneous P1 and P2 requests, serve P1 first (lowest free slot) and P2 the next free slot; same coordinate -> P2 dropped.
REQ-016 SHALL use the registered FREE mask for allocation; a slot freed in cycle N is allocatable from N+1.
REQ-017 SHALL, on tick, decrement the fuse of every ARMED slot; fuse reaching 0 moves the slot to PENDING.
REQ-018 SHALL ignore tick for PENDING and FREE slots; a slot allocated in the same cycle as a tick is not decremented.
REQ-019 SHALL present the lowest-index PENDING slot on expl_valid/expl_coord/expl_owner, registered, holding values stable until expl_ready.
REQ-020 SHALL, on expl_valid && expl_ready, free that slot; the next PENDING slot is presented no earlier than the following cycle.
REQ-021 SHALL count ARMED+PENDING slots per owner for bomb_num_*, saturating is unnecessary since SLOTS<=7 per owner is not enforced; width 3 holds 0..7, SLOTS>7 per owner wraps and is prohibited by bench.
REQ-022 SHALL detonate exactly FUSE_TICKS ticks after placement: expl_valid rises the cycle after the FUSE_TICKS-th tick if no lower slot is pending.
REQ-023 SHALL not model chain reactions or blast range; downstream logic owns those.

Reset
REQ-024 SHALL, on rst, set all slots FREE, fuses 0, and drive expl_valid, bomb_num_*, *_drop, query_hit to 0.
REQ-025 SHALL, on rst mid-detonation, abandon the pending stream with no handshake completed.

Structure
REQ-026 SHALL place SLOTS, FUSE_TICKS defaults, the slot-state enum and the 8-bit coordinate type in shared package bomb_pkg.
REQ-027 SHALL instantiate one sub-module bomb_slot per slot (state, coord, owner, fuse counter); allocation priority, occupancy compare, counting and output register live in bomb_manager.

Verification
REQ-028 SHALL cover: P1 set at coord 0x11, 4 ticks, expl_ready=1 -> expl_valid one cycle after 4th tick, coord 0x11, owner 0, bomb_num_1 1->0.
REQ-029 SHALL cover: P1 and P2 set same cycle at 0x22 -> slot 0 owner P1, p2_drop pulses, bomb_num_1=1, bomb_num_2=0.
REQ-030 SHALL cover: 8 placements then a 9th -> drop pulse, bomb counts unchanged.
REQ-031 SHALL cover: three bombs placed same cycle pair plus next, expl_ready low 5 cycles -> expl_coord stable, then slots drain lowest-index first, one per handshake.
REQ-032 SHALL cover: rst asserted while expl_valid=1 -> all outputs 0 next edge, query_hit 0 for prior coords.
REQ-033 SHALL cover: placement in same cycle as tick -> detonation after FUSE_TICKS further ticks, not FUSE_TICKS-1.
